// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter unit.
// Pure declarations: no state, no latency.
// No flow control.
package pc_pkg;

    localparam int PC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET,
        SEL_INC
    } pc_sel_t;

    // Worked at 32 bits so any PC width fits. The caller truncates the
    // result, which gives modulo-2^PC_W wrap for both increment and
    // two's-complement branch offsets.
    function automatic logic [31:0] next_pc(
        input pc_sel_t     sel,
        input logic [31:0] pc,
        input logic [31:0] jump_addr,
        input logic [31:0] branch_off,
        input logic [31:0] call_addr,
        input logic [31:0] ret_addr
    );
        case (sel)
            SEL_HOLD:   next_pc = pc;
            SEL_JUMP:   next_pc = jump_addr;
            SEL_BRANCH: next_pc = pc + branch_off;
            SEL_CALL:   next_pc = call_addr;
            SEL_RET:    next_pc = ret_addr;
            default:    next_pc = pc + 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO of STACK_DEPTH x PC_W entries.
// Push/pop take effect on the next edge; top is a combinational read.
// Push when full and pop when empty are silently dropped.
module pc_ret_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(STACK_DEPTH);

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [AW:0]     sp;
    logic [AW-1:0]   top_idx;

    // sp counts entries; the top entry lives one slot below it.
    assign top_idx = AW'(sp - (AW+1)'(1));
    assign top     = mem[top_idx];
    assign empty   = (sp == '0);
    assign full    = (sp == FULL_CNT);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
            sp              <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Instruction-address generator: hold/jump/branch/call/ret/increment.
// One cycle: a request in cycle n shows on b after edge n+1.
// No backpressure; stall holds PC, stack and flags.
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int PC_W        = PC_W_DEFAULT,
    parameter int STACK_DEPTH = 4
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            branch,
    input  logic [PC_W-1:0] branch_off,
    input  logic            call,
    input  logic [PC_W-1:0] call_addr,
    input  logic            ret,
    input  logic            clr_err,
    output logic [PC_W-1:0] b,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            ovf,
    output logic            udf
);

    pc_sel_t         sel;
    logic            ovf_set;
    logic            udf_set;
    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] b_nxt;

    // A ret on an empty stack degrades to a plain increment.
    always_comb begin
        sel     = SEL_INC;
        udf_set = 1'b0;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch) begin
            sel = SEL_BRANCH;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (ret) begin
            if (stack_empty) begin
                udf_set = 1'b1;
            end else begin
                sel = SEL_RET;
            end
        end
    end

    assign ovf_set = (sel == SEL_CALL) && stack_full;

    assign b_nxt = PC_W'(next_pc(sel, 32'(b), 32'(jump_addr), 32'(branch_off),
                                 32'(call_addr), 32'(ret_addr)));

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (sel == SEL_CALL),
        .pop    (sel == SEL_RET),
        .din    (b + PC_W'(1)),
        .top    (ret_addr),
        .empty  (stack_empty),
        .full   (stack_full)
    );

    // A new error on the same edge as clr_err leaves the flag set.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            b   <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            b   <= b_nxt;
            ovf <= ovf_set | (ovf & ~clr_err);
            udf <= udf_set | (udf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: a reference model predicts each
// edge's outputs, queued at drive time and compared after the edge.
module tb_program_counter_unit;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    logic            sysclk = 1'b0;
    logic            rst_n;
    logic            stall, jump, branch, call, ret, clr_err;
    logic [PC_W-1:0] jump_addr, branch_off, call_addr;
    logic [PC_W-1:0] b;
    logic            stack_empty, stack_full, ovf, udf;

    typedef struct packed {
        logic [PC_W-1:0] b;
        logic            empty;
        logic            full;
        logic            ovf;
        logic            udf;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [PC_W-1:0] pc_m;
    logic [PC_W-1:0] stk_m [DEPTH];
    int              sp_m;
    logic            ovf_m, udf_m;

    int checks = 0;
    int errors = 0;

    program_counter_unit #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .branch      (branch),
        .branch_off  (branch_off),
        .call        (call),
        .call_addr   (call_addr),
        .ret         (ret),
        .clr_err     (clr_err),
        .b           (b),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        pc_m  = '0;
        sp_m  = 0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) stk_m[i] = '0;
    endtask

    task automatic idle();
        stall = 0; jump = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
        jump_addr = '0; branch_off = '0; call_addr = '0;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.b     = pc_m;
        e.empty = (sp_m == 0);
        e.full  = (sp_m == DEPTH);
        e.ovf   = ovf_m;
        e.udf   = udf_m;
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".b"},     32'(b),           32'(e.b));
        check({tag, ".empty"}, 32'(stack_empty), 32'(e.empty));
        check({tag, ".full"},  32'(stack_full),  32'(e.full));
        check({tag, ".ovf"},   32'(ovf),         32'(e.ovf));
        check({tag, ".udf"},   32'(udf),         32'(e.udf));
    endtask

    // Apply the currently driven inputs for one edge.
    task automatic cycle(input string tag);
        exp_t e;
        if (clr_err) begin
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end
        if (stall) begin
        end else if (jump) begin
            pc_m = jump_addr;
        end else if (branch) begin
            pc_m = pc_m + branch_off;
        end else if (call) begin
            if (sp_m < DEPTH) begin
                stk_m[sp_m] = pc_m + 8'd1;
                sp_m++;
            end else begin
                ovf_m = 1'b1;
            end
            pc_m = call_addr;
        end else if (ret) begin
            if (sp_m > 0) begin
                sp_m--;
                pc_m = stk_m[sp_m];
            end else begin
                pc_m  = pc_m + 8'd1;
                udf_m = 1'b1;
            end
        end else begin
            pc_m = pc_m + 8'd1;
        end
        exp_q.push_back(model_snapshot());
        @(posedge sysclk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            compare_outputs(tag, e);
        end
        idle();
    endtask

    // Assert reset away from the edge and check it took hold without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs(tag, model_snapshot());
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        compare_outputs("reset", model_snapshot());
        @(negedge sysclk);
        rst_n = 1'b1;

        // free run from 0
        for (int i = 0; i < 7; i++) cycle("free_run");
        check("free_run_end", 32'(b), 32'h07);

        // wrap through 0xFF
        jump = 1; jump_addr = 8'hFD; cycle("jump_fd");
        for (int i = 0; i < 3; i++) cycle("wrap");
        check("wrap_zero", 32'(b), 32'h00);

        // async reset mid-sequence with a non-empty stack
        call = 1; call_addr = 8'h20; cycle("pre_rst_call");
        jump = 1; jump_addr = 8'h23; cycle("pre_rst_jump");
        async_reset("async_rst");
        cycle("post_rst_inc");

        // jump / branch / priority
        jump = 1; jump_addr = 8'h40; cycle("jump_40");
        branch = 1; branch_off = 8'hFC; cycle("branch_neg4");
        jump = 1; jump_addr = 8'h10; branch = 1; branch_off = 8'h33; cycle("jump_over_branch");
        stall = 1; jump = 1; jump_addr = 8'h55; cycle("stall_over_jump");
        jump = 1; jump_addr = 8'h02; cycle("jump_02");
        branch = 1; branch_off = 8'hFE; cycle("branch_wrap");

        // call / return
        jump = 1; jump_addr = 8'h05; cycle("jump_05");
        call = 1; call_addr = 8'h80; cycle("call_80");
        cycle("sub_inc1");
        cycle("sub_inc2");
        ret = 1; cycle("ret_06");

        // overflow and LIFO order
        call = 1; call_addr = 8'h10; cycle("call1");
        call = 1; call_addr = 8'h20; cycle("call2");
        call = 1; call_addr = 8'h30; cycle("call3");
        call = 1; call_addr = 8'h40; cycle("call4_full");
        stall = 1; call = 1; call_addr = 8'h99; ret = 1; cycle("stall_masks_call_ret");
        branch = 1; branch_off = 8'h01; call = 1; call_addr = 8'h77; cycle("branch_masks_call");
        call = 1; call_addr = 8'hA0; cycle("call5_ovf");
        for (int i = 0; i < 4; i++) begin
            ret = 1; cycle("ret_lifo");
        end
        clr_err = 1; cycle("clr_ovf");

        // underflow and clear
        jump = 1; jump_addr = 8'h30; cycle("jump_30");
        ret = 1; cycle("ret_empty_udf");
        clr_err = 1; cycle("clr_udf");
        clr_err = 1; ret = 1; cycle("clr_vs_new_udf");
        stall = 1; clr_err = 1; cycle("stall_clr");
        cycle("final_inc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got time %0t expected < 20000", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- 8-bit instruction-address generator for the project's simple CPU datapath.
- Output b holds the current program counter and feeds instruction memory.
- Every clock, PC increments by default. Control inputs can instead hold it, jump absolute, branch relative, or call/return through a small internal return-address stack.

Parameters:
- PC_W, 8, program-counter width in bits.
- STACK_DEPTH, 4, number of return-address stack entries (power of two, ≥2).

Ports:
- sysclk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and stack unchanged this cycle.
- jump  input  1  load b with jump_addr.
- jump_addr  input  PC_W  absolute jump target.
- branch  input  1  add branch_off to b.
- branch_off  input  PC_W  two's-complement relative offset.
- call  input  1  push b+1, then load b with call_addr.
- call_addr  input  PC_W  subroutine target.
- ret  input  1  pop the stack top into b.
- clr_err  input  1  clear the sticky error flags.
- b  output  PC_W  current program counter.
- stack_empty  output  1  stack holds 0 entries.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- ovf  output  1  sticky flag: call issued while the stack was full.
- udf  output  1  sticky flag: ret issued while the stack was empty.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - b=0, stack pointer=0, stack contents cleared.
  - stack_empty=1, stack_full=0, ovf=0, udf=0.
- All outputs are registered.
- Latency: an action requested in cycle n is visible on b after rising edge n+1.
- Per-edge priority, exactly one action taken: stall > jump > branch > call > ret > increment.
- stall: b, stack and flags hold. clr_err is still honoured.
- jump: b <= jump_addr.
- branch: b <= (b + branch_off) mod 2^PC_W. Example: b=0x02, off=0xFE gives 0x00.
- increment: b <= (b+1) mod 2^PC_W. 0xFF wraps to 0x00 with no flag.
- call, stack not full: push (b+1) mod 2^PC_W, then b <= call_addr.
- call, stack full: b <= call_addr, push discarded, ovf <= 1.
- ret, stack not empty: b <= stack top, pop.
- ret, stack empty: b <= b+1 (treated as increment), udf <= 1.
- Flags:
  - stack_empty and stack_full are combinational decodes of the registered pointer.
  - ovf and udf stay set until clr_err=1 or reset.
  - If clr_err and a new error occur on the same edge, the new error wins (flag ends at 1).
- Out-of-range inputs: lower-priority requests asserted together with a higher one are ignored completely, with no stack or flag side effects.
- Reset asserted mid-sequence overrides everything asynchronously. The first action after rst_n deasserts uses b=0.
- With all controls at 0 and reset released, b counts 0,1,2,... one step per sysclk period.

Decomposition:
- Package pc_pkg holds:
  - PC_W default constant.
  - Enum pc_sel_t {SEL_HOLD, SEL_JUMP, SEL_BRANCH, SEL_CALL, SEL_RET, SEL_INC}, produced by the priority decoder.
  - Next-PC helper function.
- One sub-module, pc_ret_stack: LIFO of STACK_DEPTH × PC_W.
  - Inputs push, pop, din.
  - Outputs top, empty, full.
  - Shares the same sysclk and rst_n.
  - Ignores push when full and pop when empty.
- Top level contains the priority decoder, the next-PC mux, the PC register and the sticky flags.

Test Plan:
- Free run: release rst_n, all controls 0, run 7 edges -> b = 1,2,3,4,5,6,7. Continue from 0xFD -> 0xFE, 0xFF, 0x00, no flags set.
- Async reset: assert rst_n=0 between edges while b=0x23 -> b=0 immediately; stack_empty=1, ovf=udf=0.
- Jump/branch/priority:
  - jump=1, jump_addr=0x40 -> b=0x40.
  - Then branch_off=0xFC -> b=0x3C.
  - Then jump+branch together, jump_addr=0x10 -> b=0x10.
  - Then stall+jump -> b stays 0x10.
- Call/return: at b=0x05, call to 0x80 -> b=0x80, stack_empty=0. Two increments (b=0x82), then ret -> b=0x06, stack_empty=1.
- Overflow: 4 calls -> stack_full=1. 5th call to 0xA0 -> b=0xA0, ovf=1. Four rets return the four pushed addresses in LIFO order.
- Underflow and clear: ret on empty stack at b=0x30 -> b=0x31, udf=1. clr_err=1 -> udf=0 next edge. clr_err together with a new empty ret -> udf stays 1.
